// File: rtl/onchip_mem_arb_pkg.sv
// Shared widths, port ids and the command payload for the on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // A simultaneous read and write is a write; the read half is dropped.
  function automatic mem_cmd_t make_cmd(input logic [ADDR_W-1:0] addr,
                                        input logic [BE_W-1:0]   be,
                                        input logic              rd,
                                        input logic              wr,
                                        input logic [DATA_W-1:0] wdata);
    mem_cmd_t c;
    c.addr  = addr;
    c.be    = be;
    c.wr    = wr;
    c.rd    = rd & ~wr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; rr_ptr names the port that wins the next tie.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       freeze,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (!reset && !freeze) begin
      if (req == 2'b11) grant = (rr_ptr == PORT1) ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // The port just served always yields the next tie to the other one.
  always_ff @(posedge clk) begin
    if (reset)         rr_ptr <= PORT0;
    else if (grant[0]) rr_ptr <= PORT1;
    else if (grant[1]) rr_ptr <= PORT0;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port 16K x 32 RAM between a CPU port (0) and a DMA port (1)
// with round-robin grant, 1-cycle read return and saturating stall counters.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_chipselect,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_chipselect,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  input  logic              freeze,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  stall_cnt0,
  output logic [CNT_W-1:0]  stall_cnt1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       req;
  logic [1:0]       grant;
  logic             granted;
  logic             rd_issue;
  mem_cmd_t         cmd0, cmd1, cmd_sel;
  logic             rd_vld;
  logic             rd_id;
  logic [CNT_W-1:0] stall_q0, stall_q1;

  assign req[0] = p0_chipselect & (p0_read | p0_write);
  assign req[1] = p1_chipselect & (p1_read | p1_write);

  assign cmd0 = make_cmd(p0_address, p0_byteenable, p0_read, p0_write, p0_writedata);
  assign cmd1 = make_cmd(p1_address, p1_byteenable, p1_read, p1_write, p1_writedata);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .freeze (freeze),
    .grant  (grant)
  );

  assign granted  = |grant;
  assign cmd_sel  = grant[1] ? cmd1 : cmd0;
  assign rd_issue = granted & cmd_sel.rd;

  assign p0_waitrequest = req[0] & ~grant[0];
  assign p1_waitrequest = req[1] & ~grant[1];

  // Idle cycles leave the port-0 command on the bus with chipselect low.
  assign mem_address    = cmd_sel.addr;
  assign mem_byteenable = cmd_sel.be;
  assign mem_writedata  = cmd_sel.wdata;
  assign mem_chipselect = granted;
  assign mem_write      = granted & cmd_sel.wr;
  assign mem_clken      = 1'b1;

  // Read return tracks which port owns the data coming back next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_id  <= PORT0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rd_id <= grant[1];
    end
  end

  // A response in flight when reset arrives is dropped.
  assign p0_readdatavalid = rd_vld & ~reset & (rd_id == PORT0);
  assign p1_readdatavalid = rd_vld & ~reset & (rd_id == PORT1);
  assign p0_readdata      = p0_readdatavalid ? mem_readdata : '0;
  assign p1_readdata      = p1_readdatavalid ? mem_readdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q0 <= '0;
      stall_q1 <= '0;
    end else begin
      if (cnt_clear)                                  stall_q0 <= '0;
      else if (p0_waitrequest && stall_q0 != CNT_MAX) stall_q0 <= stall_q0 + CNT_W'(1);
      if (cnt_clear)                                  stall_q1 <= '0;
      else if (p1_waitrequest && stall_q1 != CNT_MAX) stall_q1 <= stall_q1 + CNT_W'(1);
    end
  end

  assign stall_cnt0 = stall_q0;
  assign stall_cnt1 = stall_q1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM, port-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_onchip_mem_arbiter;

  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_chipselect, p0_read, p0_write;
  logic        p1_chipselect, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic        freeze, cnt_clear;
  logic [3:0]  stall_cnt0, stall_cnt1;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  onchip_mem_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_chipselect(p0_chipselect),
    .p0_read(p0_read), .p0_write(p0_write), .p0_writedata(p0_writedata),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_chipselect(p1_chipselect),
    .p1_read(p1_read), .p1_write(p1_write), .p1_writedata(p1_writedata),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .freeze(freeze), .cnt_clear(cnt_clear), .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [31:0] ram [16384];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state, kept at the level of ports and memory words.
  logic [31:0] m_mem [16384];
  int          m_rr = 0;
  bit          pend_vld = 1'b0;
  int          pend_port = 0;
  logic [31:0] pend_data = '0;
  int          s0 = 0, s1 = 0;
  int          win;
  logic        e_w0, e_w1, e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;

  task automatic predict();
    bit r0, r1;
    r0 = p0_chipselect && (p0_read || p0_write);
    r1 = p1_chipselect && (p1_read || p1_write);
    win = -1;
    if (!reset && !freeze) begin
      if (r0 && r1) win = m_rr;
      else if (r0)  win = 0;
      else if (r1)  win = 1;
    end
    e_w0  = r0 && (win != 0);
    e_w1  = r1 && (win != 1);
    e_rv0 = pend_vld && (pend_port == 0) && !reset;
    e_rv1 = pend_vld && (pend_port == 1) && !reset;
    e_rd0 = e_rv0 ? pend_data : 32'h0;
    e_rd1 = e_rv1 ? pend_data : 32'h0;
  endtask

  task automatic advance();
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          wr;
    @(posedge clk);
    if (reset) begin
      m_rr = 0; pend_vld = 1'b0; s0 = 0; s1 = 0;
    end else begin
      if (cnt_clear) s0 = 0; else if (e_w0 && s0 < CMAX) s0++;
      if (cnt_clear) s1 = 0; else if (e_w1 && s1 < CMAX) s1++;
      pend_vld = 1'b0;
      if (win >= 0) begin
        a  = (win == 0) ? p0_address    : p1_address;
        be = (win == 0) ? p0_byteenable : p1_byteenable;
        wd = (win == 0) ? p0_writedata  : p1_writedata;
        wr = (win == 0) ? p0_write      : p1_write;
        if (wr) begin
          for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          pend_vld = 1'b1; pend_port = win; pend_data = m_mem[a];
        end
        m_rr = 1 - win;
      end
    end
    #1;
  endtask

  task automatic idle();
    p0_chipselect = 0; p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
    p1_chipselect = 0; p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
  endtask

  task automatic drive0(input bit rd, input bit wr, input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    p0_chipselect = 1; p0_read = rd; p0_write = wr; p0_address = a; p0_byteenable = be; p0_writedata = d;
  endtask

  task automatic drive1(input bit rd, input bit wr, input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    p1_chipselect = 1; p1_read = rd; p1_write = wr; p1_address = a; p1_byteenable = be; p1_writedata = d;
  endtask

  task automatic test_reset();
    reset = 1; freeze = 0; cnt_clear = 0; idle();
    drive0(1, 0, 14'h5, 4'hF, 32'h0);
    advance(); advance();
    predict(); #1;
    checks++; if (p0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0 got %b exp 1", p0_waitrequest); end
    checks++; if (p1_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait1 got %b exp 0", p1_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem got cs=%b wr=%b exp 0 0", mem_chipselect, mem_write); end
    checks++; if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b%b exp 00", p0_readdatavalid, p1_readdatavalid); end
    checks++; if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d %0d exp 0 0", stall_cnt0, stall_cnt1); end
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken got %b exp 1", mem_clken); end
    advance();
    reset = 0; idle();
    predict(); advance();
  endtask

  task automatic test_write_read();
    drive0(0, 1, 14'h10, 4'hF, 32'hDEADBEEF);
    predict(); #1;
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait got %b exp 0", p0_waitrequest); end
    checks++; if (mem_write !== 1'b1 || mem_address !== 14'h10 || mem_writedata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL wr_mem got wr=%b a=%h d=%h exp 1 0010 deadbeef", mem_write, mem_address, mem_writedata); end
    advance();
    drive0(1, 0, 14'h10, 4'hF, 32'h0);
    predict(); #1;
    checks++; if (p0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0)
      begin errors++; $display("FAIL rd_issue got wait=%b cs=%b wr=%b exp 0 1 0", p0_waitrequest, mem_chipselect, mem_write); end
    advance();
    idle(); predict(); #1;
    checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rd_return got v=%b d=%h exp 1 deadbeef", p0_readdatavalid, p0_readdata); end
    checks++; if (p1_readdatavalid !== 1'b0 || p1_readdata !== 32'h0)
      begin errors++; $display("FAIL rd_other got v=%b d=%h exp 0 0", p1_readdatavalid, p1_readdata); end
    advance();
    predict(); #1;
    checks++; if (p0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_single got %b exp 0", p0_readdatavalid); end
    advance();
  endtask

  task automatic test_prefill();
    for (int i = 0; i < 16; i++) begin
      idle();
      if (i % 2 == 0) drive0(0, 1, 14'(i), 4'hF, $urandom);
      else            drive1(0, 1, 14'(i), 4'hF, $urandom);
      predict(); #1;
      checks++; if ((i % 2 == 0 ? p0_waitrequest : p1_waitrequest) !== 1'b0)
        begin errors++; $display("FAIL prefill_wait addr %0d got 1 exp 0", i); end
      advance();
    end
    idle(); predict(); advance();
  endtask

  task automatic test_alternating();
    int n0 = 0, n1 = 0;
    reset = 1; idle(); predict(); advance();
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 8) begin drive0(1, 0, 14'h0, 4'hF, 32'h0); drive1(1, 0, 14'h1, 4'hF, 32'h0); end
      predict(); #1;
      if (i < 8) begin
        checks++; if (p0_waitrequest !== 1'(i % 2) || p1_waitrequest !== 1'(1 - i % 2))
          begin errors++; $display("FAIL alt_wait cyc %0d got %b%b exp %b%b", i, p0_waitrequest, p1_waitrequest, 1'(i % 2), 1'(1 - i % 2)); end
      end
      if (p0_readdatavalid) begin
        n0++;
        checks++; if (p0_readdata !== m_mem[0]) begin errors++; $display("FAIL alt_data0 got %h exp %h", p0_readdata, m_mem[0]); end
      end
      if (p1_readdatavalid) begin
        n1++;
        checks++; if (p1_readdata !== m_mem[1]) begin errors++; $display("FAIL alt_data1 got %h exp %h", p1_readdata, m_mem[1]); end
      end
      advance();
    end
    checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL alt_pulses got %0d %0d exp 4 4", n0, n1); end
    idle(); predict(); #1;
    checks++; if (stall_cnt0 !== 4'd4 || stall_cnt1 !== 4'd4)
      begin errors++; $display("FAIL alt_stall got %0d %0d exp 4 4", stall_cnt0, stall_cnt1); end
    advance();
  endtask

  task automatic test_byte_write();
    idle(); drive0(0, 1, 14'h20, 4'hF, 32'h11223344); predict(); advance();
    idle(); drive1(0, 1, 14'h20, 4'h2, 32'h0000AB00); predict(); advance();
    idle(); drive0(1, 0, 14'h20, 4'hF, 32'h0);        predict(); advance();
    idle(); predict(); #1;
    checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'h1122AB44)
      begin errors++; $display("FAIL byte_merge got v=%b d=%h exp 1 1122ab44", p0_readdatavalid, p0_readdata); end
    advance();
  endtask

  task automatic test_freeze();
    idle(); cnt_clear = 1; predict(); advance(); cnt_clear = 0;
    drive0(1, 0, 14'h10, 4'hF, 32'h0); predict(); advance();
    idle(); freeze = 1; drive1(1, 0, 14'h0, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      predict(); #1;
      checks++; if (p1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0)
        begin errors++; $display("FAIL frz_wait cyc %0d got wait=%b cs=%b exp 1 0", i, p1_waitrequest, mem_chipselect); end
      checks++; if (stall_cnt1 !== 4'(i)) begin errors++; $display("FAIL frz_cnt cyc %0d got %0d exp %0d", i, stall_cnt1, i); end
      if (i == 0) begin
        checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF)
          begin errors++; $display("FAIL frz_ret got v=%b d=%h exp 1 deadbeef", p0_readdatavalid, p0_readdata); end
      end
      advance();
    end
    freeze = 0; predict(); #1;
    checks++; if (p1_waitrequest !== 1'b0 || stall_cnt1 !== 4'd5)
      begin errors++; $display("FAIL frz_release got wait=%b cnt=%0d exp 0 5", p1_waitrequest, stall_cnt1); end
    advance();
    idle(); predict(); #1;
    checks++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== m_mem[0])
      begin errors++; $display("FAIL frz_p1data got v=%b d=%h exp 1 %h", p1_readdatavalid, p1_readdata, m_mem[0]); end
    advance();
  endtask

  task automatic test_saturate();
    idle(); cnt_clear = 1; predict(); advance(); cnt_clear = 0;
    freeze = 1; drive1(0, 1, 14'h30, 4'hF, 32'h55AA55AA);
    for (int i = 0; i < 20; i++) begin
      predict(); #1;
      checks++; if (stall_cnt1 !== 4'(i < CMAX ? i : CMAX))
        begin errors++; $display("FAIL sat_cnt cyc %0d got %0d exp %0d", i, stall_cnt1, (i < CMAX ? i : CMAX)); end
      advance();
    end
    cnt_clear = 1; predict(); advance(); cnt_clear = 0;
    predict(); #1;
    checks++; if (stall_cnt1 !== 4'd0) begin errors++; $display("FAIL sat_clear got %0d exp 0", stall_cnt1); end
    advance();
    predict(); #1;
    checks++; if (stall_cnt1 !== 4'd1) begin errors++; $display("FAIL sat_resume got %0d exp 1", stall_cnt1); end
    idle(); freeze = 0; predict(); advance();
  endtask

  task automatic test_reset_mid();
    drive0(1, 0, 14'h10, 4'hF, 32'h0); predict(); advance();
    idle(); reset = 1; predict(); #1;
    checks++; if (p0_readdatavalid !== 1'b0 || p0_readdata !== 32'h0)
      begin errors++; $display("FAIL rstmid_drop got v=%b d=%h exp 0 0", p0_readdatavalid, p0_readdata); end
    advance();
    predict(); #1;
    checks++; if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 4'd0 || p0_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0)
      begin errors++; $display("FAIL rstmid_state got c0=%0d c1=%0d v=%b cs=%b exp 0 0 0 0", stall_cnt0, stall_cnt1, p0_readdatavalid, mem_chipselect); end
    advance();
    reset = 0; drive0(1, 0, 14'h10, 4'hF, 32'h0); predict(); #1;
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_accept got %b exp 0", p0_waitrequest); end
    advance();
    idle(); predict(); #1;
    checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rstmid_resume got v=%b d=%h exp 1 deadbeef", p0_readdatavalid, p0_readdata); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p0_chipselect = ($urandom % 4) != 0; p0_read = 1'($urandom); p0_write = 1'($urandom);
      p0_address = 14'($urandom % 16); p0_byteenable = 4'($urandom); p0_writedata = $urandom;
      p1_chipselect = ($urandom % 4) != 0; p1_read = 1'($urandom); p1_write = 1'($urandom);
      p1_address = 14'($urandom % 16); p1_byteenable = 4'($urandom); p1_writedata = $urandom;
      freeze = ($urandom % 8) == 0; cnt_clear = ($urandom % 32) == 0;
      predict(); #1;
      checks++; if (p0_waitrequest !== e_w0 || p1_waitrequest !== e_w1)
        begin errors++; $display("FAIL rnd_wait cyc %0d got %b%b exp %b%b", i, p0_waitrequest, p1_waitrequest, e_w0, e_w1); end
      checks++; if (p0_readdatavalid !== e_rv0 || p0_readdata !== e_rd0)
        begin errors++; $display("FAIL rnd_rd0 cyc %0d got %b %h exp %b %h", i, p0_readdatavalid, p0_readdata, e_rv0, e_rd0); end
      checks++; if (p1_readdatavalid !== e_rv1 || p1_readdata !== e_rd1)
        begin errors++; $display("FAIL rnd_rd1 cyc %0d got %b %h exp %b %h", i, p1_readdatavalid, p1_readdata, e_rv1, e_rd1); end
      checks++; if (stall_cnt0 !== 4'(s0) || stall_cnt1 !== 4'(s1))
        begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d %0d exp %0d %0d", i, stall_cnt0, stall_cnt1, s0, s1); end
      checks++; if (mem_chipselect !== (win >= 0))
        begin errors++; $display("FAIL rnd_cs cyc %0d got %b exp %b", i, mem_chipselect, (win >= 0)); end
      advance();
    end
    idle(); freeze = 0; cnt_clear = 0; predict(); advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_prefill();
    test_alternating();
    test_byte_write();
    test_freeze();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
